tia_audio_sched: RTL



---
 rtl/tia_audio_pkg.sv | 46 ++++
 rtl/tia_audio_freq_div.sv | 25 ++
 rtl/tia_audio_sched.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tia_audio_pkg.sv
// Shared types and constants for the TIA audio scheduler: register map,
// datapath opcode layout, shift-state seed, FSM states and channel config.
package tia_audio_pkg;

  localparam logic [2:0] ADDR_AUDC0 = 3'd0;
  localparam logic [2:0] ADDR_AUDC1 = 3'd1;
  localparam logic [2:0] ADDR_AUDF0 = 3'd2;
  localparam logic [2:0] ADDR_AUDF1 = 3'd3;
  localparam logic [2:0] ADDR_AUDV0 = 3'd4;
  localparam logic [2:0] ADDR_AUDV1 = 3'd5;

  localparam int AUDC_W = 4;
  localparam int AUDF_W = 5;
  localparam int AUDV_W = 4;

  localparam int OPC_W        = 20;
  localparam int OPC_CH_POS   = 19;
  localparam int OPC_AUDC_POS = 15;
  localparam int OPC_AUDF_POS = 10;
  localparam int OPC_AUDV_POS = 6;

  localparam int          POLY_W    = 9;
  localparam logic [8:0]  POLY_INIT = 9'h1FF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [AUDC_W-1:0] audc;
    logic [AUDF_W-1:0] audf;
    logic [AUDV_W-1:0] audv;
  } audio_ch_cfg_t;

  function automatic logic [OPC_W-1:0] make_opcode(input logic ch, input audio_ch_cfg_t cfg);
    logic [OPC_W-1:0] opc;
    opc = '0;
    opc[OPC_CH_POS]                    = ch;
    opc[OPC_AUDC_POS +: AUDC_W]        = cfg.audc;
    opc[OPC_AUDF_POS +: AUDF_W]        = cfg.audf;
    opc[OPC_AUDV_POS +: AUDV_W]        = cfg.audv;
    return opc;
  endfunction

endpackage

// File: rtl/tia_audio_freq_div.sv
// Per-channel audio frequency divider: counts audio ticks and pulses
// expire when the count matches AUDF, then restarts from zero.
module tia_audio_freq_div
  import tia_audio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [AUDF_W-1:0] audf,
  output logic              expire
);

  logic [AUDF_W-1:0] cnt;

  // A count already past AUDF runs on to 31, wraps, and matches later.
  assign expire = tick && (cnt == audf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (tick)
      cnt <= expire ? '0 : cnt + AUDF_W'(1);
  end

endmodule

// File: rtl/tia_audio_sched.sv
// TIA audio scheduler: shadow registers, tick/divider timing and a shared
// polynomial datapath time-multiplexed across two channels. TIA_AUDIO_MIX_EN adds mix_out.
//
// state   | meaning
// IDLE    | no step in flight; arbitrate pending channels
// BUSY    | dp_req held for sel_q until dp_done or timeout
module tia_audio_sched
  import tia_audio_pkg::*;
#(
  parameter int TICK_DIV   = 114,
  parameter int DP_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic              dp_req,
  output logic [OPC_W-1:0]  dp_opcode,
  output logic [POLY_W-1:0] dp_state_in,
  input  logic              dp_done,
  input  logic [POLY_W-1:0] dp_state_out,
  output logic [3:0]        amp0,
  output logic [3:0]        amp1,
  output logic [1:0]        overrun,
  output logic              dp_err
`ifdef TIA_AUDIO_MIX_EN
  ,
  output logic [4:0]        mix_out
`endif
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DP_TIMEOUT + 1);

  audio_ch_cfg_t      cfg [2];
  logic [POLY_W-1:0]  poly [2];
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [1:0]         expire, arm, pending, done_ch, clr;
  sched_state_e       state_q, state_d;
  logic               sel_q, sel_d, last_q, last_d;
  logic               dp_req_d, done_ok, tmo;
  logic [OPC_W-1:0]   opc_d;
  logic [POLY_W-1:0]  sin_d;
  logic [DW-1:0]      tmr_q, tmr_d;
  logic               unused_wr;

  assign unused_wr = ^wr_data[7:5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg[0] <= '0;
      cfg[1] <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_AUDC0: cfg[0].audc <= wr_data[AUDC_W-1:0];
        ADDR_AUDC1: cfg[1].audc <= wr_data[AUDC_W-1:0];
        ADDR_AUDF0: cfg[0].audf <= wr_data[AUDF_W-1:0];
        ADDR_AUDF1: cfg[1].audf <= wr_data[AUDF_W-1:0];
        ADDR_AUDV0: cfg[0].audv <= wr_data[AUDV_W-1:0];
        ADDR_AUDV1: cfg[1].audv <= wr_data[AUDV_W-1:0];
        default: ;
      endcase
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_cnt <= '0;
    else
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  tia_audio_freq_div u_div0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .audf   (cfg[0].audf),
    .expire (expire[0])
  );

  tia_audio_freq_div u_div1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .audf   (cfg[1].audf),
    .expire (expire[1])
  );

  assign arm[0]  = expire[0] && (cfg[0].audc != '0);
  assign arm[1]  = expire[1] && (cfg[1].audc != '0);
  assign done_ch = {done_ok & sel_q, done_ok & ~sel_q};
  assign clr     = done_ch | {tmo & sel_q, tmo & ~sel_q};

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    dp_req_d = dp_req;
    opc_d    = dp_opcode;
    sin_d    = dp_state_in;
    tmr_d    = tmr_q;
    done_ok  = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          // Both pending: serve the channel that did not go last.
          sel_d    = (pending == 2'b11) ? ~last_q : pending[1];
          last_d   = sel_d;
          state_d  = ST_BUSY;
          dp_req_d = 1'b1;
          opc_d    = make_opcode(sel_d, cfg[sel_d]);
          sin_d    = poly[sel_d];
          tmr_d    = DW'(DP_TIMEOUT - 1);
        end
      end
      ST_BUSY: begin
        if (dp_done) begin
          done_ok  = 1'b1;
          dp_req_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (tmr_q == '0) begin
          tmo      = 1'b1;
          dp_req_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          tmr_d = tmr_q - DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      dp_req      <= 1'b0;
      dp_opcode   <= '0;
      dp_state_in <= '0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      dp_req      <= dp_req_d;
      dp_opcode   <= opc_d;
      dp_state_in <= sin_d;
      tmr_q       <= tmr_d;
    end
  end

  // Completion clears pending before a same-cycle expiry re-arms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
      dp_err  <= 1'b0;
      poly[0] <= POLY_INIT;
      poly[1] <= POLY_INIT;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (arm[ch]) begin
          if (pending[ch] && !clr[ch])
            overrun[ch] <= 1'b1;
          else
            pending[ch] <= 1'b1;
        end else if (clr[ch]) begin
          pending[ch] <= 1'b0;
        end
        if (done_ch[ch])
          poly[ch] <= dp_state_out;
      end
      if (tmo)
        dp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp0 <= '0;
      amp1 <= '0;
    end else begin
      amp0 <= (cfg[0].audc == '0 || poly[0][0]) ? cfg[0].audv : 4'd0;
      amp1 <= (cfg[1].audc == '0 || poly[1][0]) ? cfg[1].audv : 4'd0;
    end
  end

`ifdef TIA_AUDIO_MIX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mix_out <= '0;
    else
      mix_out <= {1'b0, amp0} + {1'b0, amp1};
  end
`endif

endmodule
